// File: rtl/banco_registros_param_if.sv
// Register-file access bundle: read address/data ports, single write port, ready flag.
// Latency: purely structural, no timing of its own.
// Backpressure: none; requester waits for ready before relying on reads or writes.
interface banco_registros_param_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);

  logic [NUM_READ*ADDR_W-1:0] read_reg;
  logic [NUM_READ*DATA_W-1:0] read_data;
  logic [ADDR_W-1:0]          write_reg;
  logic [DATA_W-1:0]          write_data;
  logic                       reg_write;
  logic                       ready;

  // Decode/writeback side drives addresses and write data.
  modport master (
    output read_reg,
    output write_reg,
    output write_data,
    output reg_write,
    input  read_data,
    input  ready
  );

  // Register file side.
  modport slave (
    input  read_reg,
    input  write_reg,
    input  write_data,
    input  reg_write,
    output read_data,
    output ready
  );

endinterface

// File: rtl/banco_registros_param.sv
// MIPS GPR file: NUM_READ combinational read ports, one synchronous write port, post-reset clear sweep.
// Latency: reads 0 cycles; writes visible after the edge (same cycle with BANCO_REGISTROS_BYPASS_EN).
// Backpressure: none; ready=0 for DEPTH cycles after reset, during which writes drop and reads return 0.
module banco_registros_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  banco_registros_param_if.slave bus
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsmState_e;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH-1);
  localparam bit                ZeroHard = (ZERO_REG != 0);

  // Storage deliberately has no reset so it maps onto RAM; the sweep clears it.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  fsmState_e         state;
  fsmState_e         stateNext;
  logic [ADDR_W-1:0] sweepCnt;
  logic [ADDR_W-1:0] sweepCntNext;
  logic              readyQ;
  logic              readyNext;
  logic              sweepClr;
  logic              writeOk;
  logic [NUM_READ*DATA_W-1:0] rdVec;

  // A write lands only once ready, in range, and not aimed at a hardwired r0.
  assign writeOk = readyQ && bus.reg_write
                   && ({1'b0, bus.write_reg} < DepthLim)
                   && !(ZeroHard && (bus.write_reg == '0));

  // State register with synchronous active-low reset; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      sweepCnt <= '0;
      readyQ   <= 1'b0;
    end else begin
      state    <= stateNext;
      sweepCnt <= sweepCntNext;
      readyQ   <= readyNext;
    end
  end

  // Next-state: INIT walks every entry once, then RUN holds until reset.
  always_comb begin
    stateNext    = state;
    sweepCntNext = sweepCnt;
    readyNext    = readyQ;
    sweepClr     = 1'b0;
    case (state)
      INIT: begin
        sweepClr  = 1'b1;
        readyNext = 1'b0;
        if (sweepCnt == LastIdx) begin
          stateNext    = RUN;
          readyNext    = 1'b1;
          sweepCntNext = '0;
        end else begin
          sweepCntNext = sweepCnt + 1'b1;
        end
      end
      RUN: begin
        readyNext = 1'b1;
      end
      default: begin
        stateNext = INIT;
        readyNext = 1'b0;
      end
    endcase
  end

  // Single write port shared by the clear sweep and functional writes (never both at once).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweepClr) begin
        mem[sweepCnt] <= '0;
      end else if (writeOk) begin
        mem[bus.write_reg] <= bus.write_data;
      end
    end
  end

  // Combinational read ports, zero while not ready, out of range, or r0 when hardwired.
  always_comb begin
    logic [ADDR_W-1:0] rdAddr;
    rdVec  = '0;
    rdAddr = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rdAddr = bus.read_reg[k*ADDR_W +: ADDR_W];
      if (readyQ && ({1'b0, rdAddr} < DepthLim) && !(ZeroHard && (rdAddr == '0))) begin
        rdVec[k*DATA_W +: DATA_W] = mem[rdAddr];
      end
`ifdef BANCO_REGISTROS_BYPASS_EN
      // Write-through: writeOk already excludes r0 when hardwired and out-of-range targets.
      if (writeOk && (bus.write_reg == rdAddr)) begin
        rdVec[k*DATA_W +: DATA_W] = bus.write_data;
      end
`else
      // Without forwarding the old contents are returned until the edge.
`endif
    end
  end

  assign bus.read_data = rdVec;
  assign bus.ready     = readyQ;

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: default instance plus DEPTH=24 / ZERO_REG=0 / 3-port instance.
// Directed scenarios followed by randomized traffic against an array-based reference model.
// Expected read values honour BANCO_REGISTROS_BYPASS_EN when it is defined for the build.
module tb_banco_registros_param;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  banco_registros_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus0 ();
  banco_registros_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(3)) bus1 ();

  banco_registros_param #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  banco_registros_param #(
    .DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_READ(3), .ZERO_REG(0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int nVec = 0;
  int nMis = 0;

  // Stimulus held between steps
  bit          rstN;
  bit          we0, we1;
  int          wa0, wa1;
  logic [31:0] wd0, wd1;
  int          ra0 [2];
  int          ra1 [3];

  // Reference model: array contents plus ready/sweep progress per instance
  logic [31:0] m0 [32];
  logic [31:0] m1 [24];
  bit          rdy0, rdy1;
  int          swp0, swp1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legalWr(int d, int a);
    int depth = (d == 0) ? 32 : 24;
    bit zero  = (d == 0);
    return (a < depth) && !(zero && a == 0);
  endfunction

  function automatic logic [31:0] expRd(int d, int a);
    int          depth = (d == 0) ? 32 : 24;
    bit          zero  = (d == 0);
    bit          rdy   = (d == 0) ? rdy0 : rdy1;
    bit          we    = (d == 0) ? we0 : we1;
    int          wa    = (d == 0) ? wa0 : wa1;
    logic [31:0] wd    = (d == 0) ? wd0 : wd1;
    if (!rdy) return 32'h0;
    if (a >= depth) return 32'h0;
    if (zero && a == 0) return 32'h0;
`ifdef BANCO_REGISTROS_BYPASS_EN
    if (we && wa == a && legalWr(d, wa)) return wd;
`else
    if (we && wa == a && legalWr(d, wa) && 1'b0) return wd;
`endif
    return (d == 0) ? m0[a] : m1[a];
  endfunction

  // Advance the model across one rising edge using the held inputs
  task automatic modelEdge();
    if (!rstN) begin
      rdy0 = 1'b0; swp0 = 0;
      rdy1 = 1'b0; swp1 = 0;
    end else begin
      if (!rdy0) begin
        swp0++;
        if (swp0 == 32) begin
          rdy0 = 1'b1;
          foreach (m0[i]) m0[i] = 32'h0;
        end
      end else if (we0 && legalWr(0, wa0)) begin
        m0[wa0] = wd0;
      end
      if (!rdy1) begin
        swp1++;
        if (swp1 == 24) begin
          rdy1 = 1'b1;
          foreach (m1[i]) m1[i] = 32'h0;
        end
      end else if (we1 && legalWr(1, wa1)) begin
        m1[wa1] = wd1;
      end
    end
  endtask

  // One clock: drive at negedge, check settled outputs, then update the model after the edge
  task automatic step();
    @(negedge clk);
    rst_n           = rstN;
    bus0.reg_write  = we0;
    bus0.write_reg  = wa0[4:0];
    bus0.write_data = wd0;
    bus0.read_reg   = {ra0[1][4:0], ra0[0][4:0]};
    bus1.reg_write  = we1;
    bus1.write_reg  = wa1[4:0];
    bus1.write_data = wd1;
    bus1.read_reg   = {ra1[2][4:0], ra1[1][4:0], ra1[0][4:0]};
    #1;
    checkVal("d0_ready", {31'b0, bus0.ready}, {31'b0, rdy0});
    checkVal("d1_ready", {31'b0, bus1.ready}, {31'b0, rdy1});
    for (int k = 0; k < 2; k++)
      checkVal($sformatf("d0_rd%0d_a%0d", k, ra0[k]), bus0.read_data[k*32 +: 32], expRd(0, ra0[k]));
    for (int k = 0; k < 3; k++)
      checkVal($sformatf("d1_rd%0d_a%0d", k, ra1[k]), bus1.read_data[k*32 +: 32], expRd(1, ra1[k]));
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  task automatic noWrite();
    we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    int n;
    rstN = 1'b0;
    we0 = 1'b0; wa0 = 0; wd0 = '0;
    we1 = 1'b0; wa1 = 0; wd1 = '0;
    ra0 = '{0, 0};
    ra1 = '{0, 0, 0};
    rdy0 = 1'b0; rdy1 = 1'b0; swp0 = 0; swp1 = 0;
    foreach (m0[i]) m0[i] = 32'h0;
    foreach (m1[i]) m1[i] = 32'h0;
    rst_n = 1'b0;
    bus0.reg_write = 1'b0; bus0.write_reg = '0; bus0.write_data = '0; bus0.read_reg = '0;
    bus1.reg_write = 1'b0; bus1.write_reg = '0; bus1.write_data = '0; bus1.read_reg = '0;

    // Init sweep length: ready after exactly DEPTH edges with reset released
    ra0 = '{5, 31};
    ra1 = '{1, 23, 30};
    step();
    step();
    rstN = 1'b1;
    n = 0;
    while (!bus0.ready && n < 100) begin
      step();
      n++;
    end
    checkVal("init_edges", n, 32);

    // Basic write/read, including last legal index of each instance
    we0 = 1; wa0 = 5;  wd0 = 32'hDEADBEEF;
    we1 = 1; wa1 = 23; wd1 = 32'hCAFEF00D;
    step();
    we0 = 1; wa0 = 31; wd0 = 32'h12345678;
    we1 = 1; wa1 = 30; wd1 = 32'h0BADF00D;
    step();
    noWrite();
    ra0 = '{5, 31};
    ra1 = '{23, 30, 5};
    step();
    checkVal("t2_p0_r5",  bus0.read_data[31:0],  32'hDEADBEEF);
    checkVal("t2_p1_r31", bus0.read_data[63:32], 32'h12345678);
    checkVal("t6_r23",    bus1.read_data[31:0],  32'hCAFEF00D);
    checkVal("t6_r30",    bus1.read_data[63:32], 32'h0);
    ra0 = '{31, 5};
    step();
    checkVal("t2_p0_r31", bus0.read_data[31:0],  32'h12345678);
    checkVal("t2_p1_r5",  bus0.read_data[63:32], 32'hDEADBEEF);

    // Register zero: hardwired in dut0, ordinary in dut1
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
    we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
    step();
    noWrite();
    ra0 = '{0, 0};
    ra1 = '{0, 0, 0};
    step();
    checkVal("t3_zero_hw",  bus0.read_data[31:0], 32'h0);
    checkVal("t3_zero_ord", bus1.read_data[31:0], 32'hFFFFFFFF);

    // Same-cycle read-after-write on r7
    we0 = 1; wa0 = 7; wd0 = 32'h1;
    we1 = 1; wa1 = 7; wd1 = 32'h1;
    ra0 = '{7, 7};
    ra1 = '{7, 7, 7};
    step();
    we0 = 1; wd0 = 32'hA5A5A5A5;
    we1 = 1; wd1 = 32'hA5A5A5A5;
    step();
    noWrite();
    step();
    checkVal("t4_r7_after", bus0.read_data[31:0], 32'hA5A5A5A5);

    // Mid-sweep reset plus a write attempted during the sweep
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    ra0 = '{3, 5};
    ra1 = '{3, 5, 23};
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        we0 = 1; wa0 = 3; wd0 = 32'h77;
        we1 = 1; wa1 = 3; wd1 = 32'h77;
      end else begin
        noWrite();
      end
      step();
    end
    noWrite();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    n = 0;
    while (!bus0.ready && n < 100) begin
      step();
      n++;
    end
    checkVal("t5_restart_edges", n, 32);
    step();
    checkVal("t5_r3_cleared", bus0.read_data[31:0], 32'h0);
    checkVal("t5_r5_cleared", bus0.read_data[63:32], 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rstN = ($urandom_range(0, 299) != 0);
      we0 = ($urandom_range(0, 2) != 0);
      wa0 = $urandom_range(0, 31);
      wd0 = $urandom;
      we1 = ($urandom_range(0, 2) != 0);
      wa1 = $urandom_range(0, 31);
      wd1 = $urandom;
      ra0[0] = ($urandom_range(0, 3) == 0) ? wa0 : $urandom_range(0, 31);
      ra0[1] = $urandom_range(0, 31);
      ra1[0] = ($urandom_range(0, 3) == 0) ? wa1 : $urandom_range(0, 31);
      ra1[1] = $urandom_range(0, 31);
      ra1[2] = $urandom_range(20, 31);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
